riscv_ctrl_exec: RTL and testbench

//  Decode-and-execute slice of the single-cycle RV32 core: main control decoder, ALU-control decoder and 32-bit ALU in one block.

---
 rtl/riscv_ctrl_pkg.sv | 35 +++
 rtl/riscv_alu_core.sv | 34 +++
 rtl/riscv_ctrl_exec.sv | 120 ++++++++++++
 tb/tb_riscv_ctrl_exec.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32 decode/execute slice: opcodes and control-field enums.
package riscv_ctrl_pkg;

   localparam logic [6:0] OpcR    = 7'b0110011;
   localparam logic [6:0] OpcIAlu = 7'b0010011;
   localparam logic [6:0] OpcLw   = 7'b0000011;
   localparam logic [6:0] OpcSw   = 7'b0100011;
   localparam logic [6:0] OpcBeq  = 7'b1100011;
   localparam logic [6:0] OpcJal  = 7'b1101111;

   typedef enum logic [1:0] {
      AluOpMem    = 2'b00,
      AluOpBranch = 2'b01,
      AluOpR      = 2'b10,
      AluOpI      = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      AluAnd = 3'b000,
      AluOr  = 3'b001,
      AluAdd = 3'b010,
      AluXor = 3'b011,
      AluSll = 3'b100,
      AluSrl = 3'b101,
      AluSub = 3'b110,
      AluSlt = 3'b111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      PcPlus4 = 2'b00,
      PcBeq   = 2'b01,
      PcJal   = 2'b10
   } pc_src_e;

endpackage

// File: rtl/riscv_alu_core.sv
// Purely combinational ALU: selected operation on A/B plus a zero flag on the result.
module riscv_alu_core
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  alu_ctrl_e          alu_ctrl_i,
   input  logic [Width-1:0]   a_i,
   input  logic [Width-1:0]   b_i,
   output logic [Width-1:0]   result_o,
   output logic               zero_o
);

   logic lt;

   assign lt = $signed(a_i) < $signed(b_i);

   always_comb begin
      result_o = '0;
      unique case (alu_ctrl_i)
         AluAnd: result_o = a_i & b_i;
         AluOr:  result_o = a_i | b_i;
         AluAdd: result_o = a_i + b_i;
         AluXor: result_o = a_i ^ b_i;
         AluSll: result_o = a_i << b_i[4:0];
         AluSrl: result_o = a_i >> b_i[4:0];
         AluSub: result_o = a_i - b_i;
         AluSlt: result_o = {{(Width-1){1'b0}}, lt};
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/riscv_ctrl_exec.sv
// Decode-and-execute slice: main decoder, ALU-control decoder and ALU; en_q masks
// the control outputs while in reset and for the first cycle out of it.
module riscv_ctrl_exec
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instruction,
   input  logic [XLEN-1:0] rd1,
   input  logic [XLEN-1:0] rd2,
   input  logic [XLEN-1:0] imm32,
   output logic [1:0]      alu_op,
   output logic [2:0]      alu_ctrl,
   output logic [1:0]      pc_src,
   output logic            reg_wr,
   output logic            alu_src,
   output logic            mem_reg,
   output logic            mem_wr,
   output logic            mem_rd,
   output logic            ALU_zero,
   output logic [XLEN-1:0] ALU_out32
);

   logic            en_d, en_q;
   alu_op_e         alu_op_s;
   alu_ctrl_e       alu_ctrl_s;
   pc_src_e         pc_src_s;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            f7b;
   logic [XLEN-1:0] op_b;

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign f7b    = instruction[30];

   assign en_d = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) en_q <= 1'b0;
      else     en_q <= en_d;
   end

   always_comb begin
      alu_op_s = AluOpMem;
      pc_src_s = PcPlus4;
      reg_wr   = 1'b0;
      alu_src  = 1'b0;
      mem_reg  = 1'b0;
      mem_wr   = 1'b0;
      mem_rd   = 1'b0;
      if (en_q) begin
         case (opcode)
            OpcR: begin
               alu_op_s = AluOpR;
               reg_wr   = 1'b1;
            end
            OpcIAlu: begin
               alu_op_s = AluOpI;
               reg_wr   = 1'b1;
               alu_src  = 1'b1;
            end
            OpcLw: begin
               reg_wr  = 1'b1;
               alu_src = 1'b1;
               mem_reg = 1'b1;
               mem_rd  = 1'b1;
            end
            OpcSw: begin
               alu_src = 1'b1;
               mem_wr  = 1'b1;
            end
            OpcBeq: begin
               alu_op_s = AluOpBranch;
               pc_src_s = PcBeq;
            end
            OpcJal:  pc_src_s = PcJal;
            default: ;
         endcase
      end
   end

   always_comb begin
      alu_ctrl_s = AluAdd;
      unique case (alu_op_s)
         AluOpMem:    alu_ctrl_s = AluAdd;
         AluOpBranch: alu_ctrl_s = AluSub;
         AluOpR, AluOpI: begin
            unique case (funct3)
               3'b000: alu_ctrl_s = (f7b && alu_op_s == AluOpR) ? AluSub : AluAdd;
               3'b001: alu_ctrl_s = AluSll;
               3'b010: alu_ctrl_s = AluSlt;
               3'b011: alu_ctrl_s = AluAdd;
               3'b100: alu_ctrl_s = AluXor;
               3'b101: alu_ctrl_s = AluSrl;
               3'b110: alu_ctrl_s = AluOr;
               3'b111: alu_ctrl_s = AluAnd;
            endcase
         end
      endcase
   end

   assign alu_op   = alu_op_s;
   assign alu_ctrl = alu_ctrl_s;
   assign pc_src   = pc_src_s;
   assign op_b     = alu_src ? imm32 : rd2;

   riscv_alu_core #(
      .Width (XLEN)
   ) u_alu (
      .alu_ctrl_i (alu_ctrl_s),
      .a_i        (rd1),
      .b_i        (op_b),
      .result_o   (ALU_out32),
      .zero_o     (ALU_zero)
   );

endmodule

// File: tb/tb_riscv_ctrl_exec.sv
// Directed self-checking bench for riscv_ctrl_exec.
module tb_riscv_ctrl_exec;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instruction = 32'h0;
   logic [31:0] rd1 = 32'h0;
   logic [31:0] rd2 = 32'h0;
   logic [31:0] imm32 = 32'h0;
   logic [1:0]  alu_op;
   logic [2:0]  alu_ctrl;
   logic [1:0]  pc_src;
   logic        reg_wr, alu_src, mem_reg, mem_wr, mem_rd, ALU_zero;
   logic [31:0] ALU_out32;
   logic [8:0]  ctl;

   int n_checks = 0;
   int n_err    = 0;

   assign ctl = {alu_op, pc_src, reg_wr, alu_src, mem_reg, mem_wr, mem_rd};

   riscv_ctrl_exec #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .rd1         (rd1),
      .rd2         (rd2),
      .imm32       (imm32),
      .alu_op      (alu_op),
      .alu_ctrl    (alu_ctrl),
      .pc_src      (pc_src),
      .reg_wr      (reg_wr),
      .alu_src     (alu_src),
      .mem_reg     (mem_reg),
      .mem_wr      (mem_wr),
      .mem_rd      (mem_rd),
      .ALU_zero    (ALU_zero),
      .ALU_out32   (ALU_out32)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; instruction = 32'h002081B3; rd1 = 32'd5; rd2 = 32'd7;
      @(posedge clk); @(posedge clk); #1;
      n_checks++;
      if (ctl !== 9'b0) begin
         n_err++; $display("FAIL rst_ctl: got %b want %b", ctl, 9'b0);
      end
      n_checks++;
      if (alu_ctrl !== 3'b010) begin
         n_err++; $display("FAIL rst_alu_ctrl: got %b want 010", alu_ctrl);
      end
      n_checks++;
      if (ALU_out32 !== 32'd12) begin
         n_err++; $display("FAIL rst_alu_out: got %h want %h", ALU_out32, 32'd12);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (ctl !== 9'b10_00_1_0_0_0_0) begin
         n_err++; $display("FAIL add_ctl: got %b want %b", ctl, 9'b10_00_1_0_0_0_0);
      end
      n_checks++;
      if (ALU_out32 !== 32'd12 || alu_ctrl !== 3'b010) begin
         n_err++; $display("FAIL add_out: got %h/%b want %h/010", ALU_out32, alu_ctrl, 32'd12);
      end
   endtask

   task automatic test_r_type();
      instruction = 32'h40208133; rd1 = 32'h1234; rd2 = 32'h1234; #1;
      n_checks++;
      if (alu_ctrl !== 3'b110 || ALU_out32 !== 32'h0 || ALU_zero !== 1'b1) begin
         n_err++; $display("FAIL sub: got %b/%h/%b want 110/0/1", alu_ctrl, ALU_out32, ALU_zero);
      end
      rd1 = 32'hF0F0; rd2 = 32'hFF00;
      instruction = 32'h0020F1B3; #1;
      n_checks++;
      if (alu_ctrl !== 3'b000 || ALU_out32 !== 32'hF000 || ALU_zero !== 1'b0) begin
         n_err++; $display("FAIL and: got %b/%h/%b want 000/f000/0", alu_ctrl, ALU_out32, ALU_zero);
      end
      instruction = 32'h0020E1B3; #1;
      n_checks++;
      if (alu_ctrl !== 3'b001 || ALU_out32 !== 32'hFFF0) begin
         n_err++; $display("FAIL or: got %b/%h want 001/fff0", alu_ctrl, ALU_out32);
      end
      instruction = 32'h0020C1B3; #1;
      n_checks++;
      if (alu_ctrl !== 3'b011 || ALU_out32 !== 32'h0FF0) begin
         n_err++; $display("FAIL xor: got %b/%h want 011/0ff0", alu_ctrl, ALU_out32);
      end
      instruction = 32'h0020B1B3; #1;  // funct3 011 falls back to ADD
      n_checks++;
      if (alu_ctrl !== 3'b010 || ALU_out32 !== 32'h1EFF0) begin
         n_err++; $display("FAIL f3_011: got %b/%h want 010/1eff0", alu_ctrl, ALU_out32);
      end
      rd1 = 32'h8000_0000; rd2 = 32'h1;
      instruction = 32'h0020A1B3; #1;
      n_checks++;
      if (alu_ctrl !== 3'b111 || ALU_out32 !== 32'h1) begin
         n_err++; $display("FAIL slt_r: got %b/%h want 111/1", alu_ctrl, ALU_out32);
      end
   endtask

   task automatic test_i_type();
      instruction = 32'hFFF08093; rd1 = 32'h1; rd2 = 32'h55; imm32 = 32'hFFFF_FFFF; #1;
      n_checks++;
      if (ctl !== 9'b11_00_1_1_0_0_0) begin
         n_err++; $display("FAIL addi_ctl: got %b want %b", ctl, 9'b11_00_1_1_0_0_0);
      end
      n_checks++;
      if (alu_ctrl !== 3'b010 || ALU_out32 !== 32'h0 || ALU_zero !== 1'b1) begin
         n_err++; $display("FAIL addi: got %b/%h/%b want 010/0/1", alu_ctrl, ALU_out32, ALU_zero);
      end
      instruction = 32'h0010A093; rd1 = 32'hFFFF_FFFE; imm32 = 32'h1; #1;
      n_checks++;
      if (alu_ctrl !== 3'b111 || ALU_out32 !== 32'h1 || ALU_zero !== 1'b0) begin
         n_err++; $display("FAIL slti: got %b/%h/%b want 111/1/0", alu_ctrl, ALU_out32, ALU_zero);
      end
   endtask

   task automatic test_mem();
      instruction = 32'h0040A183; rd1 = 32'h100; rd2 = 32'hDEAD; imm32 = 32'h4; #1;
      n_checks++;
      if (ctl !== 9'b00_00_1_1_1_0_1) begin
         n_err++; $display("FAIL lw_ctl: got %b want %b", ctl, 9'b00_00_1_1_1_0_1);
      end
      n_checks++;
      if (ALU_out32 !== 32'h104 || alu_ctrl !== 3'b010) begin
         n_err++; $display("FAIL lw_addr: got %h/%b want 104/010", ALU_out32, alu_ctrl);
      end
      instruction = 32'h0030A223; #1;
      n_checks++;
      if (ctl !== 9'b00_00_0_1_0_1_0) begin
         n_err++; $display("FAIL sw_ctl: got %b want %b", ctl, 9'b00_00_0_1_0_1_0);
      end
   endtask

   task automatic test_branch_jump();
      instruction = 32'h00208463; rd1 = 32'd9; rd2 = 32'd9; imm32 = 32'h8; #1;
      n_checks++;
      if (ctl !== 9'b01_01_0_0_0_0_0 || alu_ctrl !== 3'b110 || ALU_zero !== 1'b1) begin
         n_err++; $display("FAIL beq_eq: got %b/%b/%b want 010100000/110/1", ctl, alu_ctrl, ALU_zero);
      end
      rd2 = 32'd8; #1;
      n_checks++;
      if (ALU_zero !== 1'b0 || ALU_out32 !== 32'h1) begin
         n_err++; $display("FAIL beq_ne: got %b/%h want 0/1", ALU_zero, ALU_out32);
      end
      instruction = 32'h0080006F; #1;
      n_checks++;
      if (ctl !== 9'b00_10_0_0_0_0_0) begin
         n_err++; $display("FAIL jal_ctl: got %b want %b", ctl, 9'b00_10_0_0_0_0_0);
      end
      instruction = 32'h0000007F; #1;
      n_checks++;
      if (ctl !== 9'b0 || alu_ctrl !== 3'b010) begin
         n_err++; $display("FAIL nop_ctl: got %b/%b want 0/010", ctl, alu_ctrl);
      end
   endtask

   task automatic test_shifts();
      instruction = 32'h002091B3; rd1 = 32'h1; rd2 = 32'h21; #1;
      n_checks++;
      if (alu_ctrl !== 3'b100 || ALU_out32 !== 32'h2) begin
         n_err++; $display("FAIL sll: got %b/%h want 100/2", alu_ctrl, ALU_out32);
      end
      instruction = 32'h0020D1B3; rd1 = 32'h8000_0000; rd2 = 32'd31; #1;
      n_checks++;
      if (alu_ctrl !== 3'b101 || ALU_out32 !== 32'h1) begin
         n_err++; $display("FAIL srl: got %b/%h want 101/1", alu_ctrl, ALU_out32);
      end
      instruction = 32'h4020D1B3; rd2 = 32'd4; #1;
      n_checks++;
      if (ALU_out32 !== 32'h0800_0000) begin
         n_err++; $display("FAIL srl_logical: got %h want 08000000", ALU_out32);
      end
   endtask

   task automatic test_mid_reset();
      instruction = 32'h002081B3; rd1 = 32'd3; rd2 = 32'd4;
      @(negedge clk); rst = 1'b1; #1;
      n_checks++;
      if (reg_wr !== 1'b1) begin
         n_err++; $display("FAIL midrst_before: got reg_wr=%b want 1", reg_wr);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ctl !== 9'b0 || ALU_out32 !== 32'd7) begin
         n_err++; $display("FAIL midrst_after: got %b/%h want 0/7", ctl, ALU_out32);
      end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (reg_wr !== 1'b1 || alu_op !== 2'b10) begin
         n_err++; $display("FAIL midrst_release: got %b/%b want 1/10", reg_wr, alu_op);
      end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_i_type();
      test_mem();
      test_branch_jump();
      test_shifts();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
